// File: rtl/hazard_control_unit.sv
// Stalls, bubbles and flushes the 5-stage pipeline for load-use, multi-cycle divide and taken branches.
// Registered FSM state and divide counter; every output is combinational from state and inputs.
module hazard_control_unit #(
  parameter int DIV_CYCLES = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [6:0] ID_OPCODE,
  input  logic [4:0] ID_ADDR1,
  input  logic [4:0] ID_ADDR2,
  input  logic [4:0] EXE_ADDR,
  input  logic       EXE_MEMREAD,
  input  logic       EXE_DIV,
  input  logic       BRANCH_TAKEN,
  output logic       PC_STALL,
  output logic       IF_ID_STALL,
  output logic       ID_EX_STALL,
  output logic       IF_ID_FLUSH,
  output logic       ID_EX_BUBBLE,
  output logic       EX_MEM_BUBBLE,
  output logic       DIV_START,
  output logic [1:0] STATE
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [5:0] CNT_INIT = 6'(DIV_CYCLES - 2);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic rs1_used, rs2_used, load_use;

  // Store data (rs2) is left out: the MEM-stage store-data forward already covers it.
  always_comb begin
    rs1_used = (ID_OPCODE == OPC_JALR)  || (ID_OPCODE == OPC_LOAD) ||
               (ID_OPCODE == OPC_STORE) || (ID_OPCODE == OPC_OPIMM) ||
               (ID_OPCODE == OPC_OP)    || (ID_OPCODE == OPC_BRANCH);
    rs2_used = (ID_OPCODE == OPC_OP)    || (ID_OPCODE == OPC_BRANCH);
    load_use = EXE_MEMREAD && (EXE_ADDR != 5'd0) &&
               ((rs1_used && (ID_ADDR1 == EXE_ADDR)) ||
                (rs2_used && (ID_ADDR2 == EXE_ADDR)));
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PC_STALL      = 1'b0;
    IF_ID_STALL   = 1'b0;
    ID_EX_STALL   = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    DIV_START     = 1'b0;
    STATE         = 2'd0;

    if (!RESET) begin
      STATE = state_q;
      case (state_q)
        S_IDLE: begin
          if (BRANCH_TAKEN) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end else if (EXE_DIV) begin
            DIV_START     = 1'b1;
            PC_STALL      = 1'b1;
            IF_ID_STALL   = 1'b1;
            ID_EX_STALL   = 1'b1;
            EX_MEM_BUBBLE = 1'b1;
            cnt_d         = CNT_INIT;
            state_d       = S_DIV;
          end else if (load_use) begin
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end
        end
        S_DIV: begin
          PC_STALL      = 1'b1;
          IF_ID_STALL   = 1'b1;
          ID_EX_STALL   = 1'b1;
          EX_MEM_BUBBLE = 1'b1;
          if (cnt_q == 6'd0) begin
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        S_DONE: begin
          // The finished divide is still in EX, so EXE_DIV must not restart it.
          if (BRANCH_TAKEN) begin
            IF_ID_FLUSH  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end else if (load_use) begin
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_BUBBLE = 1'b1;
          end
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit with DIV_CYCLES=4; inputs change on the falling edge,
// outputs are checked 1ns later, well clear of the rising edge.
module tb_hazard_control_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] id_opcode;
  logic [4:0] id_addr1, id_addr2, exe_addr;
  logic       exe_memread, exe_div, branch_taken;
  logic       pc_stall, if_id_stall, id_ex_stall, if_id_flush;
  logic       id_ex_bubble, ex_mem_bubble, div_start;
  logic [1:0] state;

  int total = 0;
  int bad   = 0;

  // Packed view: PC,IFID_STALL,IDEX_STALL,FLUSH,IDEX_BUBBLE,EXMEM_BUBBLE,DIV_START,STATE[1:0]
  logic [8:0] obs;
  assign obs = {pc_stall, if_id_stall, id_ex_stall, if_id_flush,
                id_ex_bubble, ex_mem_bubble, div_start, state};

  localparam logic [8:0] E_NONE   = 9'b000_000_0_00;
  localparam logic [8:0] E_LU     = 9'b110_010_0_00;
  localparam logic [8:0] E_LU_DN  = 9'b110_010_0_10;
  localparam logic [8:0] E_START  = 9'b111_001_1_00;
  localparam logic [8:0] E_DIV    = 9'b111_001_0_01;
  localparam logic [8:0] E_DONE   = 9'b000_000_0_10;
  localparam logic [8:0] E_BRANCH = 9'b000_110_0_00;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  always #5 clk = ~clk;

  hazard_control_unit #(.DIV_CYCLES(4)) dut (
    .CLK(clk), .RESET(reset), .ID_OPCODE(id_opcode), .ID_ADDR1(id_addr1),
    .ID_ADDR2(id_addr2), .EXE_ADDR(exe_addr), .EXE_MEMREAD(exe_memread),
    .EXE_DIV(exe_div), .BRANCH_TAKEN(branch_taken), .PC_STALL(pc_stall),
    .IF_ID_STALL(if_id_stall), .ID_EX_STALL(id_ex_stall), .IF_ID_FLUSH(if_id_flush),
    .ID_EX_BUBBLE(id_ex_bubble), .EX_MEM_BUBBLE(ex_mem_bubble),
    .DIV_START(div_start), .STATE(state)
  );

  task automatic drive(input logic rst, input logic [6:0] opc, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [4:0] ea, input logic mr,
                       input logic dv, input logic br);
    @(negedge clk);
    reset = rst; id_opcode = opc; id_addr1 = a1; id_addr2 = a2;
    exe_addr = ea; exe_memread = mr; exe_div = dv; branch_taken = br;
    #1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, OP_R, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
      total++;
      if (obs !== E_NONE) begin
        bad++; $display("FAIL reset_hold[%0d] got=%b want=%b", i, obs, E_NONE);
      end
    end
    drive(1'b0, OP_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== E_NONE) begin
      bad++; $display("FAIL reset_release got=%b want=%b", obs, E_NONE);
    end
  endtask

  task automatic test_load_use;
    logic [6:0] opc [7];
    logic [4:0] a1 [7];
    logic [4:0] a2 [7];
    logic [4:0] ea [7];
    logic [8:0] exp_v [7];
    opc = '{OP_R,   OP_R,   OP_R,   OP_STORE, OP_STORE, OP_IMM, OP_BR};
    a1  = '{5'd3,   5'd3,   5'd3,   5'd3,     5'd5,     5'd3,   5'd3};
    a2  = '{5'd5,   5'd5,   5'd0,   5'd5,     5'd3,     5'd5,   5'd5};
    ea  = '{5'd5,   5'd6,   5'd0,   5'd5,     5'd5,     5'd5,   5'd5};
    exp_v = '{E_LU, E_NONE, E_NONE, E_NONE,   E_LU,     E_NONE, E_LU};
    for (int i = 0; i < 7; i++) begin
      drive(1'b0, opc[i], a1[i], a2[i], ea[i], 1'b1, 1'b0, 1'b0);
      total++;
      if (obs !== exp_v[i]) begin
        bad++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs, exp_v[i]);
      end
      drive(1'b0, opc[i], a1[i], a2[i], ea[i], 1'b0, 1'b0, 1'b0);
      total++;
      if (obs !== E_NONE) begin
        bad++; $display("FAIL load_use_after[%0d] got=%b want=%b", i, obs, E_NONE);
      end
    end
    drive(1'b0, OP_LUI, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0);
    total++;
    if (obs !== E_NONE) begin
      bad++; $display("FAIL load_use_lui got=%b want=%b", obs, E_NONE);
    end
  endtask

  task automatic test_branch_priority;
    drive(1'b0, OP_R, 5'd3, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1);
    total++;
    if (obs !== E_BRANCH) begin
      bad++; $display("FAIL branch_over_lu got=%b want=%b", obs, E_BRANCH);
    end
    drive(1'b0, OP_R, 5'd3, 5'd4, 5'd5, 1'b0, 1'b1, 1'b1);
    total++;
    if (obs !== E_BRANCH) begin
      bad++; $display("FAIL branch_over_div got=%b want=%b", obs, E_BRANCH);
    end
    drive(1'b0, OP_R, 5'd3, 5'd4, 5'd5, 1'b0, 1'b0, 1'b0);
    total++;
    if (obs !== E_NONE) begin
      bad++; $display("FAIL branch_after got=%b want=%b", obs, E_NONE);
    end
  endtask

  task automatic test_divide;
    logic [8:0] exp_v [6];
    exp_v = '{E_START, E_DIV, E_DIV, E_DIV, E_DONE, E_NONE};
    for (int c = 0; c < 6; c++) begin
      // Cycle T+2 also presents a branch and a load-use, both of which DIV must ignore.
      if (c == 2) drive(1'b0, OP_R, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1, 1'b1);
      else        drive(1'b0, OP_R, 5'd1, 5'd2, 5'd7, 1'b0, (c < 5), 1'b0);
      total++;
      if (obs !== exp_v[c]) begin
        bad++; $display("FAIL divide[T+%0d] got=%b want=%b", c, obs, exp_v[c]);
      end
    end
  endtask

  task automatic test_reset_mid_divide;
    logic [8:0] exp_v [5];
    exp_v = '{E_START, E_DIV, E_NONE, E_NONE, E_NONE};
    for (int c = 0; c < 5; c++) begin
      drive((c == 2), OP_R, 5'd1, 5'd2, 5'd7, 1'b0, (c < 2), 1'b0);
      total++;
      if (obs !== exp_v[c]) begin
        bad++; $display("FAIL reset_mid_div[T+%0d] got=%b want=%b", c, obs, exp_v[c]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [8:0] exp_v [11];
    int starts;
    exp_v = '{E_START, E_DIV, E_DIV, E_DIV, E_DONE,
              E_START, E_DIV, E_DIV, E_DIV, E_LU_DN, E_NONE};
    starts = 0;
    for (int c = 0; c < 11; c++) begin
      // Second DONE sees a load-use and must still stall for it.
      if (c == 9) drive(1'b0, OP_R, 5'd9, 5'd2, 5'd9, 1'b1, 1'b1, 1'b0);
      else        drive(1'b0, OP_R, 5'd1, 5'd2, 5'd7, 1'b0, (c < 10), 1'b0);
      if (div_start === 1'b1) starts++;
      total++;
      if (obs !== exp_v[c]) begin
        bad++; $display("FAIL back_to_back[T+%0d] got=%b want=%b", c, obs, exp_v[c]);
      end
    end
    total++;
    if (starts != 2) begin
      bad++; $display("FAIL div_start_count got=%0d want=2", starts);
    end
  endtask

  initial begin
    reset = 1'b1; id_opcode = '0; id_addr1 = '0; id_addr2 = '0; exe_addr = '0;
    exe_memread = 1'b0; exe_div = 1'b0; branch_taken = 1'b0;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_divide();
    test_reset_mid_divide();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
